// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU op codes, forwarding selects and the
// control fields carried by the ID/EX and EX/MEM pipeline registers.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    // 2'b11 is not listed and falls back to the register-file operand.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Raw 3-bit op is kept so illegal codes survive into Execute.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [4:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_write;
        logic [4:0] rd;
    } ex_mem_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add, sub, and, or, signed slt; any other code yields zero
// and raises illegal_o.
module alu_core #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);
    import alu_pkg::*;

    logic lt;

    assign lt = $signed(a_i) < $signed(b_i);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, lt};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage: ID/EX register, forwarding muxes, ALU, EX/MEM register.
// ZeroE is combinational from the instruction currently in Execute.
module alu_execute_stage #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      RdD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            ZeroE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            ValidM,
    output logic            IllegalM
);
    import alu_pkg::*;

    id_ex_t            ctrl_e_q, ctrl_e_d;
    logic [XLEN-1:0]   rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d, imm_e_q, imm_e_d;
    ex_mem_t           ctrl_m_q, ctrl_m_d;
    logic [XLEN-1:0]   alu_result_m_q, alu_result_m_d, write_data_m_q, write_data_m_d;

    logic [XLEN-1:0]   src_a_e, src_b_e, write_data_e, alu_result_e;
    logic              illegal_e;

    // ID/EX: flush beats stall beats load.
    always_comb begin
        ctrl_e_d = ctrl_e_q;
        rd1_e_d  = rd1_e_q;
        rd2_e_d  = rd2_e_q;
        imm_e_d  = imm_e_q;
        if (FlushE) begin
            ctrl_e_d = '0;
            rd1_e_d  = '0;
            rd2_e_d  = '0;
            imm_e_d  = '0;
        end else if (!StallE) begin
            ctrl_e_d = '{valid: ValidD, reg_write: RegWriteD, alu_src: ALUSrcD,
                         alu_op: ALUControlD, rd: RdD};
            rd1_e_d  = RD1D;
            rd2_e_d  = RD2D;
            imm_e_d  = ImmExtD;
        end
    end

    always_comb begin
        src_a_e = rd1_e_q;
        case (ForwardAE)
            FWD_MEM: src_a_e = alu_result_m_q;
            FWD_WB:  src_a_e = ResultW;
            default: src_a_e = rd1_e_q;
        endcase
        write_data_e = rd2_e_q;
        case (ForwardBE)
            FWD_MEM: write_data_e = alu_result_m_q;
            FWD_WB:  write_data_e = ResultW;
            default: write_data_e = rd2_e_q;
        endcase
    end

    assign src_b_e = ctrl_e_q.alu_src ? imm_e_q : write_data_e;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .a_i      (src_a_e),
        .b_i      (src_b_e),
        .op_i     (ctrl_e_q.alu_op),
        .result_o (alu_result_e),
        .illegal_o(illegal_e)
    );

    assign ZeroE = (alu_result_e == '0);

    // A stalled Execute instruction sends a bubble forward so it reaches Memory exactly once.
    always_comb begin
        ctrl_m_d       = '0;
        alu_result_m_d = '0;
        write_data_m_d = '0;
        if (!(StallE && !FlushE)) begin
            ctrl_m_d.valid     = ctrl_e_q.valid;
            ctrl_m_d.illegal   = ctrl_e_q.valid & illegal_e;
            ctrl_m_d.reg_write = ctrl_e_q.reg_write & ctrl_e_q.valid & ~illegal_e;
            ctrl_m_d.rd        = ctrl_e_q.rd;
            alu_result_m_d     = alu_result_e;
            write_data_m_d     = write_data_e;
        end
    end

    // NOTE: state updates use non-blocking assignments; the async reset clears
    // every pipeline register, since a stale valid bit would issue a phantom write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_q       <= '0;
            rd1_e_q        <= '0;
            rd2_e_q        <= '0;
            imm_e_q        <= '0;
            ctrl_m_q       <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
        end else begin
            ctrl_e_q       <= ctrl_e_d;
            rd1_e_q        <= rd1_e_d;
            rd2_e_q        <= rd2_e_d;
            imm_e_q        <= imm_e_d;
            ctrl_m_q       <= ctrl_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
        end
    end

    assign ALUResultM = alu_result_m_q;
    assign WriteDataM = write_data_m_q;
    assign RdM        = ctrl_m_q.rd;
    assign RegWriteM  = ctrl_m_q.reg_write;
    assign ValidM     = ctrl_m_q.valid;
    assign IllegalM   = ctrl_m_q.illegal;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: hand-computed vectors covering ops,
// forwarding, stall/flush interplay, illegal codes and asynchronous reset.
module tb_alu_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallE, FlushE, ValidD, ALUSrcD, RegWriteD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, ResultW;
    logic [4:0]  RdD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ZeroE, RegWriteM, ValidM, IllegalM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_execute_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .ValidD     (ValidD),
        .ALUControlD(ALUControlD),
        .ALUSrcD    (ALUSrcD),
        .RegWriteD  (RegWriteD),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ImmExtD    (ImmExtD),
        .RdD        (RdD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ResultW    (ResultW),
        .ZeroE      (ZeroE),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .ValidM     (ValidM),
        .IllegalM   (IllegalM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic src, input logic rw,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rd);
        ValidD      = v;
        ALUControlD = op;
        ALUSrcD     = src;
        RegWriteD   = rw;
        RD1D        = a;
        RD2D        = b;
        ImmExtD     = imm;
        RdD         = rd;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        reset = 1'b1;
        StallE = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
        idle();
        #12;
        check("rst_result", ALUResultM, 32'd0);
        check("rst_valid", {31'd0, ValidM}, 32'd0);
        check("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("rst_zero", {31'd0, ZeroE}, 32'd1);
        reset = 1'b0;
        tick();

        // add 5 + 7
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd3);
        tick();
        idle();
        tick();
        check("add_result", ALUResultM, 32'd12);
        check("add_regwrite", {31'd0, RegWriteM}, 32'd1);
        check("add_valid", {31'd0, ValidM}, 32'd1);
        check("add_rd", {27'd0, RdM}, 32'd3);

        // sub 3 - 3 gives zero in E
        drive(1'b1, 3'b001, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, 5'd4);
        tick();
        check("sub_zeroE", {31'd0, ZeroE}, 32'd1);
        idle();
        tick();
        check("sub_result", ALUResultM, 32'd0);
        check("sub_valid", {31'd0, ValidM}, 32'd1);

        // slt -1 < 1, then slt 1 < -1, back to back
        drive(1'b1, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5);
        tick();
        check("slt1_zeroE", {31'd0, ZeroE}, 32'd0);
        drive(1'b1, 3'b101, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd6);
        tick();
        check("slt1_result", ALUResultM, 32'd1);
        check("slt2_zeroE", {31'd0, ZeroE}, 32'd1);
        idle();
        tick();
        check("slt2_result", ALUResultM, 32'd0);

        // and / or
        drive(1'b1, 3'b010, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1);
        tick();
        drive(1'b1, 3'b011, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1);
        tick();
        check("and_result", ALUResultM, 32'h0000_F000);
        idle();
        tick();
        check("or_result", ALUResultM, 32'h0000_FFF0);

        // forward A from EX/MEM, B from immediate
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'h100, 32'd0, 32'd0, 5'd1);
        tick();
        drive(1'b1, 3'b000, 1'b1, 1'b1, 32'hDEAD, 32'd0, 32'd4, 5'd2);
        tick();
        check("fwdA_src_in_M", ALUResultM, 32'h100);
        ForwardAE = 2'b10;
        idle();
        tick();
        ForwardAE = 2'b00;
        check("fwdA_result", ALUResultM, 32'h104);

        // forward B from writeback into store data
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd1, 32'h55, 32'd0, 5'd2);
        tick();
        ForwardBE = 2'b01;
        ResultW   = 32'd9;
        idle();
        tick();
        ForwardBE = 2'b00;
        ResultW   = 32'd0;
        check("fwdB_writedata", WriteDataM, 32'd9);
        check("fwdB_result", ALUResultM, 32'd10);

        // single-cycle stall: bubble into M, held instruction issues once
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd2, 32'd3, 32'd0, 5'd7);
        tick();
        StallE = 1'b1;
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd100, 32'd100, 32'd0, 5'd8);
        tick();
        check("stall_validM", {31'd0, ValidM}, 32'd0);
        check("stall_resultM", ALUResultM, 32'd0);
        check("stall_held_zeroE", {31'd0, ZeroE}, 32'd0);
        StallE = 1'b0;
        tick();
        check("stall_issue_result", ALUResultM, 32'd5);
        check("stall_issue_rd", {27'd0, RdM}, 32'd7);
        check("stall_issue_valid", {31'd0, ValidM}, 32'd1);
        idle();
        tick();
        check("stall_next_result", ALUResultM, 32'd200);
        check("stall_next_rd", {27'd0, RdM}, 32'd8);

        // stall + flush: E becomes a bubble, incoming D instruction is dropped
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd1, 32'd1, 32'd0, 5'd2);
        tick();
        StallE = 1'b1;
        FlushE = 1'b1;
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd40, 32'd2, 32'd0, 5'd9);
        tick();
        check("sf_bubble_zeroE", {31'd0, ZeroE}, 32'd1);
        check("sf_prev_result", ALUResultM, 32'd2);
        StallE = 1'b0;
        FlushE = 1'b0;
        idle();
        tick();
        check("sf_dropped_valid", {31'd0, ValidM}, 32'd0);
        check("sf_dropped_result", ALUResultM, 32'd0);

        // illegal op 110 on a valid instruction
        drive(1'b1, 3'b110, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd4);
        tick();
        idle();
        tick();
        check("ill_result", ALUResultM, 32'd0);
        check("ill_illegal", {31'd0, IllegalM}, 32'd1);
        check("ill_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("ill_valid", {31'd0, ValidM}, 32'd1);

        // illegal op 100 on an invalid slot raises nothing
        drive(1'b0, 3'b100, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd4);
        tick();
        idle();
        tick();
        check("ill_inv_illegal", {31'd0, IllegalM}, 32'd0);
        check("ill_inv_regwrite", {31'd0, RegWriteM}, 32'd0);

        // asynchronous reset between edges
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd3);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'd8, 32'd8, 32'd0, 5'd3);
        tick();
        check("pre_rst_result", ALUResultM, 32'd12);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_result", ALUResultM, 32'd0);
        check("async_rst_valid", {31'd0, ValidM}, 32'd0);
        check("async_rst_regwrite", {31'd0, RegWriteM}, 32'd0);
        check("async_rst_rd", {27'd0, RdM}, 32'd0);
        check("async_rst_zeroE", {31'd0, ZeroE}, 32'd1);
        #1;
        reset = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
